// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: stage indices, default geometry, payload field layout
// and the per-slot action type used by the register chain.
package cpu_pipe_pkg;

    // Stage indices of the classic five-stage CPU pipeline registers
    localparam int unsigned STG_IFID  = 0;
    localparam int unsigned STG_IDEX  = 1;
    localparam int unsigned STG_EXMEM = 2;
    localparam int unsigned STG_MEMWB = 3;

    // Default chain geometry
    localparam int unsigned DEF_PWIDTH = 64;
    localparam int unsigned DEF_STAGES = 4;
    localparam int unsigned DEF_CWIDTH = 32;

    // Payload layout used by the CPU top to pack/unpack a stage word
    localparam int unsigned PL_PCNXT_LSB = 0;
    localparam int unsigned PL_PCNXT_W   = 16;
    localparam int unsigned PL_DATA_LSB  = 16;
    localparam int unsigned PL_DATA_W    = 32;
    localparam int unsigned PL_CTRL_LSB  = 48;
    localparam int unsigned PL_CTRL_W    = 16;

    // What a slot does on the next clock edge
    typedef enum logic [1:0] {
        SlotLoad,
        SlotHold,
        SlotBubble
    } slot_op_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot (valid, halt, payload). Works out its own hold/kill from the
// stall/flush request vectors (prefix-OR over this stage and every older one)
// and loads, keeps or bubbles accordingly.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned PWIDTH = DEF_PWIDTH,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned IDX    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_freeze,
    input  logic [STAGES-1:0] i_stall_req,
    input  logic [STAGES-1:0] i_flush_req,
    input  logic              i_src_valid,
    input  logic              i_src_halt,
    input  logic [PWIDTH-1:0] i_src_payload,
    input  logic              i_src_bubble,
    output logic              o_hold,
    output logic              o_kill,
    output logic              o_valid,
    output logic              o_halt,
    output logic [PWIDTH-1:0] o_payload
);

    logic              r_valid;
    logic              r_halt;
    logic [PWIDTH-1:0] r_payload;
    slot_op_e          w_op;

    // Shifting by IDX leaves only the requests from this stage and older ones
    assign o_hold = i_freeze | (|(i_stall_req >> IDX));
    assign o_kill = ~i_freeze & (|(i_flush_req >> IDX));

    // Flush outranks stall, stall outranks a bubble coming from upstream
    always_comb begin
        w_op = SlotLoad;
        if (o_kill) begin
            w_op = SlotBubble;
        end else if (o_hold) begin
            w_op = SlotHold;
        end else if (i_src_bubble) begin
            w_op = SlotBubble;
        end
    end

    // Slot contents; bubbles are fully zeroed so they are deterministic
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_halt    <= 1'b0;
            r_payload <= '0;
        end else begin
            case (w_op)
                SlotLoad: begin
                    r_valid   <= i_src_valid;
                    r_halt    <= i_src_halt;
                    r_payload <= i_src_payload;
                end
                SlotBubble: begin
                    r_valid   <= 1'b0;
                    r_halt    <= 1'b0;
                    r_payload <= '0;
                end
                default: begin
                    r_valid   <= r_valid;
                    r_halt    <= r_halt;
                    r_payload <= r_payload;
                end
            endcase
        end
    end

    assign o_valid   = r_valid;
    assign o_halt    = r_halt;
    assign o_payload = r_payload;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// In-order pipeline register chain with per-stage valid, stall, flush and halt-drain.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_chain
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned PWIDTH = DEF_PWIDTH,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned CWIDTH = DEF_CWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_halt,
    input  logic [PWIDTH-1:0]        in_payload,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stall_req,
    input  logic [STAGES-1:0]        flush_req,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES-1:0]        stage_halt,
    output logic [STAGES*PWIDTH-1:0] stage_payload,
    output logic                     retire,
    output logic                     hlt,
    output logic [CWIDTH-1:0]        cyc_cnt,
    output logic [CWIDTH-1:0]        ret_cnt,
    output logic [CWIDTH-1:0]        stl_cnt,
    output logic [CWIDTH-1:0]        fls_cnt
);

    logic              w_freeze;
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_kill;

    // A valid halt in the last slot freezes everything until reset
    assign w_freeze = stage_valid[STAGES-1] & stage_halt[STAGES-1];
    assign hlt      = w_freeze;
    assign in_ready = ~w_hold[0];
    assign retire   = stage_valid[STAGES-1] & ~w_hold[STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic              w_src_valid;
        logic              w_src_halt;
        logic              w_src_bubble;
        logic [PWIDTH-1:0] w_src_payload;

        if (i == 0) begin : g_head
            assign w_src_valid   = in_valid;
            assign w_src_halt    = in_halt;
            assign w_src_payload = in_payload;
            assign w_src_bubble  = 1'b0;
        end else begin : g_body
            assign w_src_valid   = stage_valid[i-1];
            assign w_src_halt    = stage_halt[i-1];
            assign w_src_payload = stage_payload[(i-1)*PWIDTH +: PWIDTH];
            // Upstream entry that stays put or is wrong-path must not be copied
            assign w_src_bubble  = w_hold[i-1] | w_kill[i-1];
        end

        pipe_stage_reg #(
            .PWIDTH (PWIDTH),
            .STAGES (STAGES),
            .IDX    (i)
        ) u_slot (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_freeze      (w_freeze),
            .i_stall_req   (stall_req),
            .i_flush_req   (flush_req),
            .i_src_valid   (w_src_valid),
            .i_src_halt    (w_src_halt),
            .i_src_payload (w_src_payload),
            .i_src_bubble  (w_src_bubble),
            .o_hold        (w_hold[i]),
            .o_kill        (w_kill[i]),
            .o_valid       (stage_valid[i]),
            .o_halt        (stage_halt[i]),
            .o_payload     (stage_payload[i*PWIDTH +: PWIDTH])
        );
    end

    // Prefix-OR invariant: a hold or kill at stage i implies one at every younger stage
    always_comb begin
        for (int i = 1; i < STAGES; i++) begin
            assert (!(w_hold[i] && !w_hold[i-1]));
            assert (!(w_kill[i] && !w_kill[i-1]));
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CWIDTH-1:0] r_cyc_cnt;
    logic [CWIDTH-1:0] r_ret_cnt;
    logic [CWIDTH-1:0] r_stl_cnt;
    logic [CWIDTH-1:0] r_fls_cnt;

    // Saturating event counters; nothing counts once the chain is frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
            r_stl_cnt <= '0;
            r_fls_cnt <= '0;
        end else begin
            if (!w_freeze && (r_cyc_cnt != '1)) begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end
            if (retire && (r_ret_cnt != '1)) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
            if (w_hold[0] && !w_freeze && (r_stl_cnt != '1)) begin
                r_stl_cnt <= r_stl_cnt + 1'b1;
            end
            if ((|flush_req) && !w_freeze && (r_fls_cnt != '1)) begin
                r_fls_cnt <= r_fls_cnt + 1'b1;
            end
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ret_cnt = r_ret_cnt;
    assign stl_cnt = r_stl_cnt;
    assign fls_cnt = r_fls_cnt;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
    assign stl_cnt = '0;
    assign fls_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Scoreboard bench for pipe_ctrl_chain (STAGES=4, PWIDTH=16, CWIDTH=4).
module tb_pipe_ctrl_chain;

    localparam int unsigned PW = 16;
    localparam int unsigned ST = 4;
    localparam int unsigned CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_halt = 1'b0;
    logic [PW-1:0]  in_payload = '0;
    logic           in_ready;
    logic [ST-1:0]  stall_req = '0;
    logic [ST-1:0]  flush_req = '0;
    logic [ST-1:0]  stage_valid;
    logic [ST-1:0]  stage_halt;
    logic [ST*PW-1:0] stage_payload;
    logic           retire;
    logic           hlt;
    logic [CW-1:0]  cyc_cnt, ret_cnt, stl_cnt, fls_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_exp;

    always #5 clk = ~clk;

    pipe_ctrl_chain #(
        .PWIDTH (PW),
        .STAGES (ST),
        .CWIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_halt       (in_halt),
        .in_payload    (in_payload),
        .in_ready      (in_ready),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .stage_valid   (stage_valid),
        .stage_halt    (stage_halt),
        .stage_payload (stage_payload),
        .retire        (retire),
        .hlt           (hlt),
        .cyc_cnt       (cyc_cnt),
        .ret_cnt       (ret_cnt),
        .stl_cnt       (stl_cnt),
        .fls_cnt       (fls_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pl(input int k);
        return stage_payload[k*PW +: PW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic [PW-1:0] p);
        in_valid   = v;
        in_halt    = h;
        in_payload = p;
    endtask

    // Monitor: every retirement must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && retire) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL retire_order: got 0x%0h expected no retirement", pl(ST-1));
            end else begin
                mon_exp = exp_q.pop_front();
                check("retire_order", {48'h0, pl(ST-1)}, {48'h0, mon_exp});
            end
        end
    end

    initial begin
        // Reset
        #2 rst = 1'b1;
        #1;
        check("rst_valid", stage_valid, 0);
        check("rst_halt", stage_halt, 0);
        check("rst_payload", stage_payload, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_hlt", hlt, 0);
        step();
        step();
        rst = 1'b0;

        // 1. Stream 1..8
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 16'(k));
            exp_q.push_back(16'(k));
            step();
            if (k == 4) begin
                check("stream_s3_valid", stage_valid[3], 1);
                check("stream_s3_payload", pl(3), 16'h0001);
            end
            if (k >= 4) check("stream_retire", retire, 1);
        end
        drive(1'b0, 1'b0, '0);
        for (int d = 0; d < 4; d++) begin
            step();
            if (d < 3) check("stream_drain_retire", retire, 1);
        end
        check("stream_empty", stage_valid, 0);

        // 2. Load-use stall at stage 1
        drive(1'b1, 1'b0, 16'h000A);
        exp_q.push_back(16'h000A);
        step();
        drive(1'b1, 1'b0, 16'h000B);
        exp_q.push_back(16'h000B);
        step();
        stall_req = 4'b0010;
        drive(1'b1, 1'b0, 16'h00C1);
        #1 check("lu_in_ready", in_ready, 0);
        step();
        check("lu_s1", {stage_valid[1], pl(1)}, {1'b1, 16'h000A});
        check("lu_s0", {stage_valid[0], pl(0)}, {1'b1, 16'h000B});
        check("lu_s2_bubble", {stage_valid[2], pl(2)}, 0);
        stall_req = '0;
        drive(1'b0, 1'b0, '0);
        #1 check("lu_in_ready_after", in_ready, 1);
        for (int d = 0; d < 5; d++) step();

        // 3. Branch flush at stage 0
        drive(1'b1, 1'b0, 16'h0009);
        exp_q.push_back(16'h0009);
        step();
        drive(1'b1, 1'b0, 16'h000C);
        step();
        flush_req = 4'b0001;
        drive(1'b1, 1'b0, 16'h000D);
        #1 check("fl_in_ready", in_ready, 1);
        step();
        check("fl_s0_bubble", {stage_valid[0], pl(0)}, 0);
        check("fl_s1_bubble", {stage_valid[1], pl(1)}, 0);
        check("fl_s2_advance", {stage_valid[2], pl(2)}, {1'b1, 16'h0009});
        flush_req = '0;
        drive(1'b0, 1'b0, '0);
        for (int d = 0; d < 5; d++) step();

        // 4. Stall at 2 with flush at 1
        drive(1'b1, 1'b0, 16'h0021);
        exp_q.push_back(16'h0021);
        step();
        drive(1'b1, 1'b0, 16'h0022);
        exp_q.push_back(16'h0022);
        step();
        drive(1'b1, 1'b0, 16'h0023);
        step();
        drive(1'b1, 1'b0, 16'h0024);
        step();
        stall_req = 4'b0100;
        flush_req = 4'b0010;
        drive(1'b0, 1'b0, '0);
        #1 check("sf_in_ready", in_ready, 0);
        step();
        check("sf_s0_bubble", {stage_valid[0], pl(0)}, 0);
        check("sf_s1_bubble", {stage_valid[1], pl(1)}, 0);
        check("sf_s2_held", {stage_valid[2], pl(2)}, {1'b1, 16'h0022});
        check("sf_s3_bubble", {stage_valid[3], pl(3)}, 0);
        stall_req = '0;
        flush_req = '0;
        for (int d = 0; d < 5; d++) step();

        // 5. Halt drain
        drive(1'b1, 1'b1, 16'h000F);
        step();
        drive(1'b1, 1'b0, 16'h0010);
        step();
        drive(1'b1, 1'b0, 16'h0011);
        step();
        drive(1'b0, 1'b0, '0);
        step();
        check("halt_hlt", hlt, 1);
        check("halt_retire", retire, 0);
        check("halt_halt_bits", stage_halt, 4'b1000);
        for (int c = 0; c < 10; c++) begin
            stall_req = 4'($urandom_range(0, 15));
            flush_req = 4'($urandom_range(0, 15));
            drive(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
            step();
            check("frz_valid", stage_valid, 4'b1110);
            check("frz_payload", stage_payload, 64'h000F_0010_0011_0000);
            check("frz_hlt", hlt, 1);
            check("frz_in_ready", in_ready, 0);
        end
        stall_req = '0;
        flush_req = '0;
        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        check("halt_rst_hlt", hlt, 0);
        check("halt_rst_valid", stage_valid, 0);
        check("halt_rst_in_ready", in_ready, 1);

        // 6. Perf counters
`ifdef PIPE_PERF_CNT_EN
        check("perf_rst_cyc", cyc_cnt, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) step();
        check("perf_cyc_sat", cyc_cnt, 4'hF);
        check("perf_stl", stl_cnt, 0);
        check("perf_ret", ret_cnt, 0);
        check("perf_fls", fls_cnt, 0);
        rst = 1'b1;
        #1;
        check("perf_async_cyc", cyc_cnt, 0);
        check("perf_async_all", {ret_cnt, stl_cnt, fls_cnt}, 0);
`else
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) step();
        check("perf_off_cyc", cyc_cnt, 0);
        check("perf_off_ret", ret_cnt, 0);
        check("perf_off_stl", stl_cnt, 0);
        check("perf_off_fls", fls_cnt, 0);
        rst = 1'b1;
        #1;
`endif
        step();
        rst = 1'b0;
        step();

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
